log_fir_tdm_engine: RTL and testbench

Time-multiplexed, log-domain FIR engine: the parametrised successor of the fully parallel log-domain tap array. Each beat evaluates PAR log-domain taps (sign/valid/log operand pairs) through Mitchell antilog multipliers, reduces them with an adder tree and accumulates across ORD/PAR beats. A `start`/`busy`/`y_valid` handshake delivers one saturated filter output per run. It sits between the log-converted input/weight delay lines and the error/update path of the FLAF datapath.

---
 rtl/log_fir_tdm_engine_if.sv | 33 +++
 rtl/log_fir_tdm_engine.sv | 156 +++++++++++++++
 tb/tb_log_fir_tdm_engine.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/log_fir_tdm_engine_if.sv
// Handshake and operand bus of the time-multiplexed log-domain FIR engine.
// The master drives the operands and start; the engine returns busy and the result.
interface log_fir_tdm_engine_if #(
  parameter int WIDTH     = 16,
  parameter int ORD       = 64,
  parameter int LOG_WIDTH = 17,
  parameter int ACC_WIDTH = WIDTH + $clog2(ORD)
);
  logic                     start;
  logic [ORD*LOG_WIDTH-1:0] filter_in_packed;
  logic [ORD-1:0]           filter_in_sign_packed;
  logic [ORD-1:0]           filter_in_valid_packed;
  logic [ORD*LOG_WIDTH-1:0] weight_in_packed;
  logic [ORD-1:0]           weight_in_sign_packed;
  logic [ORD-1:0]           weight_in_valid_packed;
  logic                     busy;
  logic [WIDTH-1:0]         y_out;
  logic [ACC_WIDTH-1:0]     y_acc;
  logic                     y_sat;
  logic                     y_valid;

  modport master (
    output start, filter_in_packed, filter_in_sign_packed, filter_in_valid_packed,
           weight_in_packed, weight_in_sign_packed, weight_in_valid_packed,
    input  busy, y_out, y_acc, y_sat, y_valid
  );

  modport slave (
    input  start, filter_in_packed, filter_in_sign_packed, filter_in_valid_packed,
           weight_in_packed, weight_in_sign_packed, weight_in_valid_packed,
    output busy, y_out, y_acc, y_sat, y_valid
  );
endinterface

// File: rtl/log_fir_tdm_engine.sv
// Log-domain FIR engine: PAR Mitchell antilog taps per beat, adder tree,
// accumulation over ORD/PAR beats, one saturated output per start.
module log_fir_tap #(
  parameter int WIDTH     = 16,
  parameter int QP        = 12,
  parameter int LOG_WIDTH = 17,
  parameter int LOG_FRAC  = 12
) (
  input  logic [LOG_WIDTH-1:0] log_x,
  input  logic [LOG_WIDTH-1:0] log_w,
  input  logic                 sign_x,
  input  logic                 sign_w,
  input  logic                 val_x,
  input  logic                 val_w,
  output logic [WIDTH-1:0]     prod
);
  localparam int SW = LOG_WIDTH + 1;
  localparam int MW = LOG_FRAC + WIDTH + 2;
  localparam logic [MW-1:0] MAG_MAX = MW'((1 << (WIDTH-1)) - 1);

  logic signed [SW-1:0]          s;
  logic signed [SW-LOG_FRAC-1:0] ip;
  logic [MW-1:0]                 m, mag;
  int                            sh;

  always_comb begin
    s  = $signed({log_x[LOG_WIDTH-1], log_x}) + $signed({log_w[LOG_WIDTH-1], log_w});
    // Dropping the fraction bits of a two's complement value is a floor
    ip = s[SW-1:LOG_FRAC];
    sh = int'(ip) + QP - LOG_FRAC;
    m  = MW'({1'b1, s[LOG_FRAC-1:0]});
    if (sh >= WIDTH)  mag = MAG_MAX;
    else if (sh >= 0) mag = m << sh;
    else              mag = m >> (-sh);
    if (mag > MAG_MAX) mag = MAG_MAX;
    prod = '0;
    if (val_x && val_w)
      prod = (sign_x ^ sign_w) ? -mag[WIDTH-1:0] : mag[WIDTH-1:0];
  end
endmodule

module log_fir_tdm_engine #(
  parameter int WIDTH     = 16,
  parameter int QP        = 12,
  parameter int ORD       = 64,
  parameter int LOG_WIDTH = 17,
  parameter int LOG_FRAC  = 12,
  parameter int PAR       = 8,
  parameter int ACC_WIDTH = WIDTH + $clog2(ORD)
) (
  input logic                 clk,
  input logic                 reset,
  log_fir_tdm_engine_if.slave bus
);
  localparam int BEATS  = ORD / PAR;
  localparam int KW     = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int STAGES = 1;
  localparam logic signed [ACC_WIDTH-1:0] Y_MAX = ACC_WIDTH'((1 <<< (WIDTH-1)) - 1);
  localparam logic signed [ACC_WIDTH-1:0] Y_MIN = ACC_WIDTH'(-(1 <<< (WIDTH-1)));

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t                         state;
  logic [KW-1:0]                  k;
  logic                           issue, issue_last, first_q, hi, lo;
  logic [STAGES:0]                vld_pipe, last_pipe;
  logic [PAR-1:0][LOG_WIDTH-1:0]  lx, lw;
  logic [PAR-1:0]                 sx, sw, vx, vw;
  logic [PAR-1:0][WIDTH-1:0]      prod_d, prod_q;
  logic signed [ACC_WIDTH-1:0]    sum, acc;

  assign issue      = (state == RUN);
  assign issue_last = issue && (k == KW'(BEATS-1));

  always_comb begin
    lx = '0; lw = '0; sx = '0; sw = '0; vx = '0; vw = '0;
    for (int j = 0; j < PAR; j++) begin
      lx[j] = bus.filter_in_packed[(int'(k)*PAR + j)*LOG_WIDTH +: LOG_WIDTH];
      lw[j] = bus.weight_in_packed[(int'(k)*PAR + j)*LOG_WIDTH +: LOG_WIDTH];
      sx[j] = bus.filter_in_sign_packed[int'(k)*PAR + j];
      sw[j] = bus.weight_in_sign_packed[int'(k)*PAR + j];
      vx[j] = bus.filter_in_valid_packed[int'(k)*PAR + j];
      vw[j] = bus.weight_in_valid_packed[int'(k)*PAR + j];
    end
  end

  for (genvar j = 0; j < PAR; j++) begin : g_tap
    log_fir_tap #(.WIDTH(WIDTH), .QP(QP), .LOG_WIDTH(LOG_WIDTH), .LOG_FRAC(LOG_FRAC)) u_tap (
      .log_x(lx[j]), .log_w(lw[j]), .sign_x(sx[j]), .sign_w(sw[j]),
      .val_x(vx[j]), .val_w(vw[j]), .prod(prod_d[j])
    );
  end

  always_comb begin
    sum = '0;
    for (int j = 0; j < PAR; j++) sum = sum + ACC_WIDTH'($signed(prod_q[j]));
  end

  assign hi = (acc > Y_MAX);
  assign lo = (acc < Y_MIN);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      k        <= '0;
      bus.busy <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.start) begin
          state    <= RUN;
          k        <= '0;
          bus.busy <= 1'b1;
        end
        RUN: if (issue_last) begin
          state <= DRAIN;
          k     <= '0;
        end else begin
          k <= k + 1'b1;
        end
        DRAIN: if (last_pipe[STAGES]) begin
          state    <= IDLE;
          bus.busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Stage 1 holds the beat's products, stage 2 folds them into acc; the
  // last beat's flag arriving at stage 2 triggers the output register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_pipe    <= '0;
      last_pipe   <= '0;
      first_q     <= 1'b0;
      prod_q      <= '0;
      acc         <= '0;
      bus.y_valid <= 1'b0;
      bus.y_acc   <= '0;
      bus.y_out   <= '0;
      bus.y_sat   <= 1'b0;
    end else begin
      vld_pipe    <= {vld_pipe[STAGES-1:0], issue};
      last_pipe   <= {last_pipe[STAGES-1:0], issue_last};
      first_q     <= issue && (k == '0);
      if (issue) prod_q <= prod_d;
      if (vld_pipe[0]) acc <= first_q ? sum : acc + sum;
      bus.y_valid <= vld_pipe[STAGES] && last_pipe[STAGES];
      if (vld_pipe[STAGES] && last_pipe[STAGES]) begin
        bus.y_acc <= acc;
        bus.y_sat <= hi || lo;
        bus.y_out <= hi ? Y_MAX[WIDTH-1:0] : (lo ? Y_MIN[WIDTH-1:0] : acc[WIDTH-1:0]);
      end
    end
  end
endmodule

// File: tb/tb_log_fir_tdm_engine.sv
// Directed bench for log_fir_tdm_engine: default build plus two small-order
// builds; expected results are queued at start and matched on y_valid.
module tb_log_fir_tdm_engine;
  localparam int WIDTH = 16, LW = 17, ORD = 64, ORD_S = 4;
  localparam int ACC0  = WIDTH + $clog2(ORD);
  localparam int ACC_S = WIDTH + $clog2(ORD_S);

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  log_fir_tdm_engine_if #(.WIDTH(WIDTH), .ORD(ORD),   .LOG_WIDTH(LW), .ACC_WIDTH(ACC0))  i0();
  log_fir_tdm_engine_if #(.WIDTH(WIDTH), .ORD(ORD_S), .LOG_WIDTH(LW), .ACC_WIDTH(ACC_S)) i1();
  log_fir_tdm_engine_if #(.WIDTH(WIDTH), .ORD(ORD_S), .LOG_WIDTH(LW), .ACC_WIDTH(ACC_S)) i2();

  log_fir_tdm_engine #(.WIDTH(WIDTH), .QP(12), .ORD(ORD), .LOG_WIDTH(LW), .LOG_FRAC(12),
    .PAR(8), .ACC_WIDTH(ACC0)) d0 (.clk(clk), .reset(reset), .bus(i0));
  log_fir_tdm_engine #(.WIDTH(WIDTH), .QP(12), .ORD(ORD_S), .LOG_WIDTH(LW), .LOG_FRAC(12),
    .PAR(4), .ACC_WIDTH(ACC_S)) d1 (.clk(clk), .reset(reset), .bus(i1));
  log_fir_tdm_engine #(.WIDTH(WIDTH), .QP(12), .ORD(ORD_S), .LOG_WIDTH(LW), .LOG_FRAC(12),
    .PAR(1), .ACC_WIDTH(ACC_S)) d2 (.clk(clk), .reset(reset), .bus(i2));

  typedef struct {int id; longint acc; longint out; bit sat; int cyc;} exp_t;
  exp_t sb[$];
  int checks = 0, failures = 0;

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s got=%0d want=%0d", tag, obs, exp_v);
    end
  endtask

  task automatic score(input int id, input logic signed [63:0] acc, input logic signed [63:0] out,
                       input logic sat);
    int f = -1;
    exp_t e;
    foreach (sb[i]) if (f < 0 && sb[i].id == id) f = i;
    checks++;
    assert (f >= 0) else begin
      failures++;
      $error("FAIL spurious_y_valid%0d got=1 want=0", id);
    end
    if (f >= 0) begin
      e = sb[f];
      sb.delete(f);
      chk($sformatf("y_acc%0d", id), acc, e.acc);
      chk($sformatf("y_out%0d", id), out, e.out);
      chk($sformatf("y_sat%0d", id), {63'd0, sat}, {63'd0, e.sat});
      chk($sformatf("latency_cyc%0d", id), cyc, e.cyc);
    end
  endtask

  always @(negedge clk) begin
    if (i0.y_valid === 1'b1) score(0, $signed(i0.y_acc), $signed(i0.y_out), i0.y_sat);
    if (i1.y_valid === 1'b1) score(1, $signed(i1.y_acc), $signed(i1.y_out), i1.y_sat);
    if (i2.y_valid === 1'b1) score(2, $signed(i2.y_acc), $signed(i2.y_out), i2.y_sat);
  end

  task automatic set0(input int i, input int lx, input int lw, input bit sx, input bit sw,
                      input bit vx, input bit vw);
    i0.filter_in_packed[i*LW +: LW] = LW'(lx);
    i0.weight_in_packed[i*LW +: LW] = LW'(lw);
    i0.filter_in_sign_packed[i]  = sx;
    i0.weight_in_sign_packed[i]  = sw;
    i0.filter_in_valid_packed[i] = vx;
    i0.weight_in_valid_packed[i] = vw;
  endtask

  task automatic clear0();
    for (int i = 0; i < ORD; i++) set0(i, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic go(input int id, input int lat, input longint acc, input longint out, input bit sat);
    exp_t e;
    @(negedge clk);
    e.id = id; e.acc = acc; e.out = out; e.sat = sat; e.cyc = cyc + 1 + lat;
    sb.push_back(e);
    case (id)
      0:       i0.start = 1'b1;
      1:       i1.start = 1'b1;
      default: i2.start = 1'b1;
    endcase
    @(negedge clk);
    i0.start = 1'b0; i1.start = 1'b0; i2.start = 1'b0;
    chk($sformatf("busy_after_start%0d", id),
        {63'd0, (id == 0) ? i0.busy : ((id == 1) ? i1.busy : i2.busy)}, 64'd1);
  endtask

  task automatic wait_drain();
    int n = 0;
    while (sb.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", sb.size(), 0);
  endtask

  task automatic chk_zero0(input string tag);
    chk({tag, "_busy"},    {63'd0, i0.busy},    0);
    chk({tag, "_y_valid"}, {63'd0, i0.y_valid}, 0);
    chk({tag, "_y_out"},   $signed(i0.y_out),   0);
    chk({tag, "_y_acc"},   $signed(i0.y_acc),   0);
    chk({tag, "_y_sat"},   {63'd0, i0.y_sat},   0);
  endtask

  // Independent Mitchell reference: explicit floor division of the log sum.
  function automatic longint tap_ref(int lx, int lw, bit sx, bit sw, bit vx, bit vw);
    int s, ip, fr;
    longint mag;
    s  = lx + lw;
    ip = (s >= 0) ? s / 4096 : -((-s + 4095) / 4096);
    fr = s - ip * 4096;
    mag = (ip >= 0) ? (longint'(4096 + fr) << ip) : longint'((4096 + fr) >> (-ip));
    if (mag > 32767) mag = 32767;
    if (!(vx && vw)) return 0;
    return (sx ^ sw) ? -mag : mag;
  endfunction

  initial begin
    int t_exp;
    int rlx[4], rlw[4];
    bit rsx[4], rsw[4], rvx[4], rvw[4];
    longint racc, rout;
    exp_t e;

    i0.start = 0; i1.start = 0; i2.start = 0;
    clear0();
    i1.filter_in_packed = '0; i1.weight_in_packed = '0;
    i1.filter_in_sign_packed = '0; i1.weight_in_sign_packed = '0;
    i1.filter_in_valid_packed = '0; i1.weight_in_valid_packed = '0;
    i2.filter_in_packed = '0; i2.weight_in_packed = '0;
    i2.filter_in_sign_packed = '0; i2.weight_in_sign_packed = '0;
    i2.filter_in_valid_packed = '0; i2.weight_in_valid_packed = '0;

    repeat (3) @(negedge clk);
    chk_zero0("reset");
    reset = 1'b1;

    for (int i = 0; i < ORD; i++) set0(i, 0, 0, 0, 0, 1, 1);
    go(0, 10, 262144, 32767, 1);
    wait_drain();
    repeat (3) @(negedge clk);
    chk("hold_y_out", $signed(i0.y_out), 32767);
    chk("hold_y_acc", $signed(i0.y_acc), 262144);

    clear0();
    set0(0, 0, 0, 0, 0, 1, 1);
    go(0, 10, 4096, 4096, 0);
    wait_drain();
    set0(5, 0, 0, 0, 1, 1, 1);
    go(0, 10, 0, 0, 0);
    wait_drain();

    clear0();
    set0(0, 4096, 2048, 0, 0, 1, 1);
    go(0, 10, 12288, 12288, 0);
    wait_drain();
    set0(0, -53248, 0, 0, 0, 1, 1);
    go(0, 10, 0, 0, 0);
    wait_drain();

    for (int i = 0; i < ORD; i++) set0(i, 4096, 0, 0, 1, 1, 1);
    go(0, 10, -524288, -32768, 1);
    wait_drain();

    // Busy pulses and a pulse on the result edge are dropped; the next cycle's start is taken.
    clear0();
    set0(0, 0, 0, 0, 0, 1, 1);
    @(negedge clk);
    i0.start = 1'b1;
    t_exp = cyc + 11;
    e.id = 0; e.acc = 4096; e.out = 4096; e.sat = 0; e.cyc = t_exp;
    sb.push_back(e);
    @(negedge clk); i0.start = 1'b0;
    repeat (2) @(negedge clk);
    i0.start = 1'b1;
    @(negedge clk); i0.start = 1'b0;
    while (cyc < t_exp - 1) @(negedge clk);
    i0.start = 1'b1;
    @(negedge clk);
    chk("yv_on_expected_cycle", {63'd0, i0.y_valid}, 1);
    e.cyc = cyc + 11;
    sb.push_back(e);
    @(negedge clk); i0.start = 1'b0;
    chk("busy_back_to_back", {63'd0, i0.busy}, 1);
    wait_drain();

    // Abort at beat 3: outputs cleared, no result for the aborted run.
    for (int i = 0; i < ORD; i++) set0(i, 0, 0, 0, 0, 1, 1);
    @(negedge clk); i0.start = 1'b1;
    @(negedge clk); i0.start = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    chk_zero0("abort");
    @(negedge clk); reset = 1'b1;
    repeat (15) @(negedge clk);
    go(0, 10, 262144, 32767, 1);
    wait_drain();

    for (int it = 0; it < 5; it++) begin
      racc = 0;
      for (int t = 0; t < 4; t++) begin
        if (it == 0) begin
          rlx[t] = 0; rlw[t] = 0; rsx[t] = 0; rsw[t] = 0; rvx[t] = 1; rvw[t] = 1;
        end else begin
          rlx[t] = int'($urandom_range(60000)) - 30000;
          rlw[t] = int'($urandom_range(60000)) - 30000;
          rsx[t] = 1'($urandom_range(1)); rsw[t] = 1'($urandom_range(1));
          rvx[t] = ($urandom_range(7) != 0); rvw[t] = ($urandom_range(7) != 0);
        end
        racc += tap_ref(rlx[t], rlw[t], rsx[t], rsw[t], rvx[t], rvw[t]);
        i1.filter_in_packed[t*LW +: LW] = LW'(rlx[t]);
        i1.weight_in_packed[t*LW +: LW] = LW'(rlw[t]);
        i1.filter_in_sign_packed[t] = rsx[t];  i1.weight_in_sign_packed[t] = rsw[t];
        i1.filter_in_valid_packed[t] = rvx[t]; i1.weight_in_valid_packed[t] = rvw[t];
      end
      i2.filter_in_packed = i1.filter_in_packed;   i2.weight_in_packed = i1.weight_in_packed;
      i2.filter_in_sign_packed = i1.filter_in_sign_packed;
      i2.weight_in_sign_packed = i1.weight_in_sign_packed;
      i2.filter_in_valid_packed = i1.filter_in_valid_packed;
      i2.weight_in_valid_packed = i1.weight_in_valid_packed;
      rout = (racc > 32767) ? 32767 : ((racc < -32768) ? -32768 : racc);
      go(1, 3, racc, rout, (rout != racc));
      wait_drain();
      go(2, 6, racc, rout, (rout != racc));
      wait_drain();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
